// File: rtl/sample_scheduler.sv
// Periodic X/Y/Z sample-set sequencer: issues three SPI register reads per tick
// and publishes the captured set atomically, flagging overruns and stalled reads.
module sample_scheduler #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SAMPLE_HZ = 100,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clr_flags,
  output logic        spi_req,
  output logic [5:0]  spi_addr,
  input  logic        spi_ack,
  input  logic [15:0] spi_rdata,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out,
  output logic        sample_valid,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WAIT_W   = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [5:0]        ADDR_X    = 6'h32;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [1:0]        r_axis;

  logic w_tick;
  logic w_capture;
  logic w_expire;

  assign w_tick    = enable && (r_tick_cnt == TICK_LAST);
  assign w_capture = (r_state == REQ) && spi_ack;
  assign w_expire  = (r_state == REQ) && !spi_ack && (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (!enable || r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_ONE;
    end
  end

  // One shadow per axis so a partial set never reaches the outputs.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shadow
      logic [15:0] r_data;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_data <= '0;
        end else if (w_capture && r_axis == 2'(gi)) begin
          r_data <= spi_rdata;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_axis       <= 2'd0;
      r_wait_cnt   <= '0;
      spi_req      <= 1'b0;
      spi_addr     <= ADDR_X;
      x_out        <= '0;
      y_out        <= '0;
      z_out        <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state    <= REQ;
            r_axis     <= 2'd0;
            r_wait_cnt <= '0;
            spi_req    <= 1'b1;
            spi_addr   <= ADDR_X;
          end
        end
        REQ: begin
          // An ack landing on the last wait cycle is still taken.
          if (spi_ack) begin
            spi_req <= 1'b0;
            if (r_axis == 2'd2) begin
              r_state <= DONE;
            end else begin
              r_state <= GAP;
              r_axis  <= r_axis + 2'd1;
            end
          end else if (r_wait_cnt == WAIT_LAST) begin
            spi_req <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_ONE;
          end
        end
        GAP: begin
          r_state    <= REQ;
          r_wait_cnt <= '0;
          spi_req    <= 1'b1;
          spi_addr   <= ADDR_X + {3'b000, r_axis, 1'b0};
        end
        DONE: begin
          x_out        <= g_shadow[0].r_data;
          y_out        <= g_shadow[1].r_data;
          z_out        <= g_shadow[2].r_data;
          sample_valid <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_tick && r_state != IDLE) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end

      if (w_expire) begin
        timeout_err <= 1'b1;
      end else if (clr_flags) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: SPI slave responder, per-cycle reference model,
// and directed scenarios with literal expectations.
module tb_sample_scheduler;

  localparam int TDIV = 10;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clr_flags;
  logic        spi_req;
  logic [5:0]  spi_addr;
  logic        spi_ack;
  logic [15:0] spi_rdata;
  logic [15:0] x_out, y_out, z_out;
  logic        sample_valid, overrun, timeout_err;

  sample_scheduler #(.CLK_HZ(1000), .SAMPLE_HZ(100), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_flags(clr_flags),
    .spi_req(spi_req), .spi_addr(spi_addr), .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .sample_valid(sample_valid), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // SPI slave: acks ack_delay cycles after spi_req rises, data chosen by address.
  int          ack_delay = 3;
  bit          manual_ack = 0;
  logic [15:0] axis_data [3];

  initial begin
    int age;
    age = 0;
    spi_ack = 1'b0;
    spi_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      spi_ack = 1'b0;
      if (manual_ack) begin
        spi_ack = 1'b1;
        spi_rdata = 16'hDEAD;
      end else if (spi_req === 1'b1) begin
        if (age == ack_delay) begin
          spi_ack = 1'b1;
          spi_rdata = axis_data[(int'(spi_addr) - 50) / 2];
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  // Reference model: phase 0 idle, 1 reading an axis, 2 gap, 3 publishing.
  int          m_cnt, m_wait, m_phase, m_axis;
  logic [15:0] m_sh [3];
  logic [15:0] m_out [3];
  bit          m_sv, m_ovr, m_to;

  task automatic model_reset();
    m_cnt = 0; m_wait = 0; m_phase = 0; m_axis = 0;
    for (int k = 0; k < 3; k++) begin
      m_sh[k] = 16'h0;
      m_out[k] = 16'h0;
    end
    m_sv = 0; m_ovr = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit tick, busy, expired;
    tick = enable && (m_cnt == TDIV - 1);
    busy = (m_phase != 0);
    expired = 0;
    m_cnt = (enable && m_cnt < TDIV - 1) ? m_cnt + 1 : 0;
    m_sv = 0;
    case (m_phase)
      0: if (tick) begin m_phase = 1; m_axis = 0; m_wait = 0; end
      1: begin
        if (spi_ack) begin
          m_sh[m_axis] = spi_rdata;
          if (m_axis == 2) m_phase = 3;
          else begin m_phase = 2; m_axis++; end
        end else if (m_wait == TMO - 1) begin
          m_phase = 0;
          expired = 1;
        end else begin
          m_wait++;
        end
      end
      2: begin m_phase = 1; m_wait = 0; end
      default: begin
        for (int k = 0; k < 3; k++) m_out[k] = m_sh[k];
        m_sv = 1;
        m_phase = 0;
      end
    endcase
    if (tick && busy) m_ovr = 1; else if (clr_flags) m_ovr = 0;
    if (expired) m_to = 1; else if (clr_flags) m_to = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) model_reset();
    chk("m_spi_req", 32'(spi_req), 32'(m_phase == 1));
    if (m_phase == 1) chk("m_spi_addr", 32'(spi_addr), 32'(50 + 2 * m_axis));
    chk("m_sample_valid", 32'(sample_valid), 32'(m_sv));
    chk("m_x_out", 32'(x_out), 32'(m_out[0]));
    chk("m_y_out", 32'(y_out), 32'(m_out[1]));
    chk("m_z_out", 32'(z_out), 32'(m_out[2]));
    chk("m_overrun", 32'(overrun), 32'(m_ovr));
    chk("m_timeout_err", 32'(timeout_err), 32'(m_to));
    if (rst) model_step();
  end

  task automatic go_idle();
    @(posedge clk); #1 enable = 1'b0;
    repeat (60) @(posedge clk);
    #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
  endtask

  task automatic wait_sv(input int bound, output bit found);
    found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (sample_valid) found = 1;
    end
  endtask

  task automatic wait_req(input int bound, output bit found);
    found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (spi_req) found = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, prev_req;
    int n_addr, hi, pulses, last, bad;
    logic [5:0] addrs [3];

    rst = 1'b0; enable = 1'b0; clr_flags = 1'b0;
    axis_data[0] = 16'h0102; axis_data[1] = 16'hFF80; axis_data[2] = 16'h4000;
    for (int k = 0; k < 3; k++) addrs[k] = 6'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_spi_req", 32'(spi_req), 32'h0);
    chk("rst_spi_addr", 32'(spi_addr), 32'h32);
    chk("rst_x_out", 32'(x_out), 32'h0);
    chk("rst_sample_valid", 32'(sample_valid), 32'h0);
    chk("rst_flags", 32'({overrun, timeout_err}), 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Nominal set, acks 3 cycles after each request
    enable = 1'b1;
    n_addr = 0; prev_req = 0; found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (spi_req && !prev_req && n_addr < 3) begin
        addrs[n_addr] = spi_addr;
        n_addr++;
      end
      prev_req = spi_req;
      if (sample_valid) found = 1;
    end
    chk("nom_sample_valid_seen", 32'(found), 32'h1);
    chk("nom_req_count", 32'(n_addr), 32'd3);
    chk("nom_addr0", 32'(addrs[0]), 32'h32);
    chk("nom_addr1", 32'(addrs[1]), 32'h34);
    chk("nom_addr2", 32'(addrs[2]), 32'h36);
    chk("nom_x_out", 32'(x_out), 32'h0102);
    chk("nom_y_out", 32'(y_out), 32'hFF80);
    chk("nom_z_out", 32'(z_out), 32'h4000);
    @(negedge clk);
    chk("nom_sv_one_cycle", 32'(sample_valid), 32'h0);

    // Timeout: slave never acks
    go_idle();
    ack_delay = 1000;
    enable = 1'b1;
    wait_req(40, found);
    chk("to_req_seen", 32'(found), 32'h1);
    chk("to_addr_first", 32'(spi_addr), 32'h32);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!spi_req) break;
      hi++;
    end
    chk("to_req_cycles", 32'(hi), 32'd16);
    chk("to_timeout_err", 32'(timeout_err), 32'h1);
    chk("to_x_kept", 32'(x_out), 32'h0102);
    chk("to_y_kept", 32'(y_out), 32'hFF80);
    chk("to_z_kept", 32'(z_out), 32'h4000);
    wait_req(40, found);
    chk("to_restart_seen", 32'(found), 32'h1);
    chk("to_restart_addr", 32'(spi_addr), 32'h32);
    @(posedge clk); #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    @(negedge clk);
    chk("to_cleared", 32'(timeout_err), 32'h0);
    repeat (13) @(posedge clk);
    #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    @(negedge clk);
    chk("to_set_wins_req", 32'(spi_req), 32'h0);
    chk("to_set_wins_flag", 32'(timeout_err), 32'h1);

    // Periodicity: acks after 1 cycle
    go_idle();
    ack_delay = 1;
    enable = 1'b1;
    wait_sv(40, found);
    chk("per_first_sv", 32'(found), 32'h1);
    pulses = 0; last = 0; bad = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        pulses++;
        if (i - last != TDIV) bad++;
        last = i;
      end
    end
    chk("per_pulses", 32'(pulses), 32'd5);
    chk("per_bad_spacing", 32'(bad), 32'd0);
    chk("per_overrun", 32'(overrun), 32'h0);

    // Overrun: acks after 4 cycles
    go_idle();
    ack_delay = 4;
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (overrun) found = 1;
    end
    chk("ovr_set", 32'(found), 32'h1);
    @(posedge clk); #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", 32'(overrun), 32'h0);

    // Ack on the 16th wait cycle is accepted
    go_idle();
    ack_delay = 15;
    axis_data[0] = 16'h1234; axis_data[1] = 16'h8001; axis_data[2] = 16'h7FFF;
    enable = 1'b1;
    wait_sv(120, found);
    chk("edge_sv_seen", 32'(found), 32'h1);
    chk("edge_x_out", 32'(x_out), 32'h1234);
    chk("edge_y_out", 32'(y_out), 32'h8001);
    chk("edge_z_out", 32'(z_out), 32'h7FFF);
    chk("edge_no_timeout", 32'(timeout_err), 32'h0);

    // Stray ack while idle
    go_idle();
    @(negedge clk); manual_ack = 1;
    @(negedge clk); manual_ack = 0;
    repeat (4) @(negedge clk);
    chk("idle_ack_x", 32'(x_out), 32'h1234);
    chk("idle_ack_req", 32'(spi_req), 32'h0);

    // Reset while reading Y
    ack_delay = 3;
    axis_data[0] = 16'h0AAA; axis_data[1] = 16'h0BBB; axis_data[2] = 16'h0CCC;
    @(posedge clk); #1 enable = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (spi_req && spi_addr == 6'h34) found = 1;
    end
    chk("mid_y_seen", 32'(found), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(spi_req), 32'h0);
    chk("mid_rst_addr", 32'(spi_addr), 32'h32);
    chk("mid_rst_x", 32'(x_out), 32'h0);
    chk("mid_rst_y", 32'(y_out), 32'h0);
    chk("mid_rst_z", 32'(z_out), 32'h0);
    chk("mid_rst_flags", 32'({sample_valid, overrun, timeout_err}), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_sv(60, found);
    chk("mid_after_sv", 32'(found), 32'h1);
    chk("mid_after_x", 32'(x_out), 32'h0AAA);
    chk("mid_after_y", 32'(y_out), 32'h0BBB);
    chk("mid_after_z", 32'(z_out), 32'h0CCC);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
